// File: rtl/idma_desc64_nch_arb.sv
// rtl/idma_desc64_nch_arb.sv - N-channel iDMA request arbiter with in-order response router
module idma_desc64_nch_arb #(
    parameter int unsigned NumChannels  = 2,
    parameter int unsigned BackendDepth = 5,
    parameter int unsigned ArbMode      = 0,
    parameter type         idma_req_t   = logic,
    parameter type         idma_rsp_t   = logic,
    parameter int unsigned IdxWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    parameter int unsigned CntWidth     = $clog2(BackendDepth + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  idma_req_t [NumChannels-1:0]       ch_req_i,
    input  logic      [NumChannels-1:0]       ch_req_valid_i,
    output logic      [NumChannels-1:0]       ch_req_ready_o,
    output idma_rsp_t [NumChannels-1:0]       ch_rsp_o,
    output logic      [NumChannels-1:0]       ch_rsp_valid_o,
    input  logic      [NumChannels-1:0]       ch_rsp_ready_i,
    output idma_req_t                         be_req_o,
    output logic                              be_req_valid_o,
    input  logic                              be_req_ready_i,
    input  idma_rsp_t                         be_rsp_i,
    input  logic                              be_rsp_valid_i,
    output logic                              be_rsp_ready_o,
    output logic      [NumChannels-1:0]       ch_busy_o,
    output logic      [CntWidth-1:0]          inflight_o,
    output logic                              err_o
);

    localparam int unsigned PtrWidth = (BackendDepth > 1) ? $clog2(BackendDepth) : 1;

    logic [IdxWidth-1:0] fifo_q [BackendDepth];
    logic [IdxWidth-1:0] fifo_d [BackendDepth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] fill_q, fill_d;
    logic [CntWidth-1:0] cnt_q [NumChannels];
    logic [CntWidth-1:0] cnt_d [NumChannels];
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic                err_q, err_d;

    logic [IdxWidth-1:0] arb_idx, grant, head;
    logic                arb_found, any_valid, fifo_full, fifo_empty;
    logic                req_hs, rsp_hs;
    int unsigned         arb_c;
    logic [31:0]         cnt_sum;

    assign fifo_full  = (fill_q == CntWidth'(BackendDepth));
    assign fifo_empty = (fill_q == '0);
    assign any_valid  = |ch_req_valid_i;
    assign head       = fifo_q[rd_ptr_q];

    // Round-robin scans from rr_ptr with wrap; fixed priority scans from index 0.
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        arb_c     = 0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            if (ArbMode == 0) begin
                arb_c = (32'(rr_ptr_q) + k) % NumChannels;
            end else begin
                arb_c = k;
            end
            if (!arb_found && ch_req_valid_i[arb_c]) begin
                arb_idx   = IdxWidth'(arb_c);
                arb_found = 1'b1;
            end
        end
    end

    assign grant          = lock_q ? lock_idx_q : arb_idx;
    assign be_req_o       = ch_req_i[grant];
    assign be_req_valid_o = rst_ni && (any_valid || lock_q) && !fifo_full;
    assign be_rsp_ready_o = rst_ni && ch_rsp_ready_i[head] && !fifo_empty;
    assign req_hs         = be_req_valid_o && be_req_ready_i;
    assign rsp_hs         = be_rsp_valid_i && be_rsp_ready_o;

    always_comb begin
        ch_req_ready_o = '0;
        ch_rsp_valid_o = '0;
        ch_rsp_o       = '0;
        ch_busy_o      = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            ch_req_ready_o[i] = rst_ni && (grant == IdxWidth'(i)) && be_req_ready_i && !fifo_full;
            ch_rsp_valid_o[i] = rst_ni && (head == IdxWidth'(i)) && be_rsp_valid_i && !fifo_empty;
            ch_rsp_o[i]       = be_rsp_i;
            ch_busy_o[i]      = (cnt_q[i] != '0);
        end
    end

    assign inflight_o = fill_q;
    assign err_o      = err_q;

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q | (be_rsp_valid_i && fifo_empty);

        if (req_hs) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == PtrWidth'(BackendDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            lock_d   = 1'b0;
            if (ArbMode == 0) begin
                rr_ptr_d = (grant == IdxWidth'(NumChannels - 1)) ? '0 : grant + 1'b1;
            end
        end else if (be_req_valid_o) begin
            // Hold the grant until the backend takes it, so the request stays stable.
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end

        if (rsp_hs) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(BackendDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        if (req_hs && !rsp_hs) begin
            fill_d = fill_q + 1'b1;
        end else if (!req_hs && rsp_hs) begin
            fill_d = fill_q - 1'b1;
        end

        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (req_hs && (grant == IdxWidth'(i)) && !(rsp_hs && (head == IdxWidth'(i)))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (rsp_hs && (head == IdxWidth'(i)) && !(req_hs && (grant == IdxWidth'(i)))) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
        fifo_q <= fifo_d;
    end

    always_comb begin
        cnt_sum = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            cnt_sum = cnt_sum + 32'(cnt_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (cnt_sum == 32'(fill_q));
        end
    end

endmodule

// File: tb/tb_idma_desc64_nch_arb.sv
// tb/tb_idma_desc64_nch_arb.sv - checks round-robin and fixed-priority arbiters against a queue model
module tb_idma_desc64_nch_arb;

    localparam int N = 4;
    localparam int D = 5;

    typedef logic [7:0] req_t;
    typedef logic [7:0] rsp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    req_t [N-1:0]        ch_req;
    logic [N-1:0]        vld;
    logic [N-1:0]        crdy;
    logic                brdy;
    rsp_t                brsp;
    logic                brsp_v;

    logic [N-1:0]        rdy_o   [2];
    rsp_t [N-1:0]        rsp_o   [2];
    logic [N-1:0]        rspv_o  [2];
    req_t                breq_o  [2];
    logic                breqv_o [2];
    logic                brspr_o [2];
    logic [N-1:0]        busy_o  [2];
    logic [2:0]          infl_o  [2];
    logic                err_os  [2];

    int n_checks = 0;
    int n_err    = 0;

    int fq     [2][$];
    int cnt_m  [2][N];
    int rr_m   [2];
    int lock_m [2];
    bit err_m  [2];
    int g_m    [2];
    int h_m    [2];
    bit ev_m   [2];
    bit push_m [2];
    bit pop_m  [2];
    bit spur_m [2];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        idma_desc64_nch_arb #(
            .NumChannels (N),
            .BackendDepth(D),
            .ArbMode     (m),
            .idma_req_t  (req_t),
            .idma_rsp_t  (rsp_t)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .ch_req_i      (ch_req),
            .ch_req_valid_i(vld),
            .ch_req_ready_o(rdy_o[m]),
            .ch_rsp_o      (rsp_o[m]),
            .ch_rsp_valid_o(rspv_o[m]),
            .ch_rsp_ready_i(crdy),
            .be_req_o      (breq_o[m]),
            .be_req_valid_o(breqv_o[m]),
            .be_req_ready_i(brdy),
            .be_rsp_i      (brsp),
            .be_rsp_valid_i(brsp_v),
            .be_rsp_ready_o(brspr_o[m]),
            .ch_busy_o     (busy_o[m]),
            .inflight_o    (infl_o[m]),
            .err_o         (err_os[m])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int m);
        fq[m].delete();
        for (int i = 0; i < N; i++) cnt_m[m][i] = 0;
        rr_m[m]   = 0;
        lock_m[m] = -1;
        err_m[m]  = 1'b0;
    endtask

    task automatic eval(input int m);
        int n, g, c, h;
        bit full, empty, ev;
        logic [N-1:0] er, erv, eb;
        n     = fq[m].size();
        full  = (n == D);
        empty = (n == 0);
        g     = lock_m[m];
        if (g < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m == 0) ? (rr_m[m] + k) % N : k;
                if (g < 0 && vld[c]) g = c;
            end
        end
        ev = rst_n && (g >= 0) && !full;
        chk($sformatf("be_req_valid[m%0d]", m), 32'(breqv_o[m]), 32'(ev));
        if (ev) chk($sformatf("be_req_data[m%0d]", m), 32'(breq_o[m]), 32'(ch_req[g]));
        er = '0;
        if (rst_n && g >= 0 && brdy && !full) er[g] = 1'b1;
        chk($sformatf("ch_req_ready[m%0d]", m), 32'(rdy_o[m] & vld), 32'(er & vld));
        h   = empty ? 0 : fq[m][0];
        erv = '0;
        if (rst_n && !empty && brsp_v) erv[h] = 1'b1;
        chk($sformatf("ch_rsp_valid[m%0d]", m), 32'(rspv_o[m]), 32'(erv));
        chk($sformatf("be_rsp_ready[m%0d]", m), 32'(brspr_o[m]), 32'(rst_n && !empty && crdy[h]));
        chk($sformatf("ch_rsp_data[m%0d]", m), 32'(rsp_o[m]), {4{brsp}});
        for (int i = 0; i < N; i++) eb[i] = (cnt_m[m][i] != 0);
        chk($sformatf("ch_busy[m%0d]", m), 32'(busy_o[m]), 32'(eb));
        chk($sformatf("inflight[m%0d]", m), 32'(infl_o[m]), 32'(n));
        chk($sformatf("err[m%0d]", m), 32'(err_os[m]), 32'(err_m[m]));
        g_m[m]    = g;
        h_m[m]    = h;
        ev_m[m]   = ev;
        push_m[m] = ev && brdy;
        pop_m[m]  = rst_n && !empty && brsp_v && crdy[h];
        spur_m[m] = brsp_v && empty;
    endtask

    task automatic update(input int m);
        if (!rst_n) begin
            model_clear(m);
        end else begin
            if (pop_m[m]) begin
                cnt_m[m][h_m[m]]--;
                void'(fq[m].pop_front());
            end
            if (push_m[m]) begin
                fq[m].push_back(g_m[m]);
                cnt_m[m][g_m[m]]++;
                if (m == 0) rr_m[m] = (g_m[m] + 1) % N;
                lock_m[m] = -1;
            end else if (ev_m[m]) begin
                lock_m[m] = g_m[m];
            end
            if (spur_m[m]) err_m[m] = 1'b1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        for (int m = 0; m < 2; m++) eval(m);
        @(posedge clk);
        for (int m = 0; m < 2; m++) update(m);
        #1;
    endtask

    task automatic idle_inputs();
        vld    = '0;
        brdy   = 1'b0;
        brsp_v = 1'b0;
        crdy   = '1;
        for (int i = 0; i < N; i++) ch_req[i] = req_t'(8'h10 + i);
        brsp   = 8'hA5;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) model_clear(m);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_inflight", 32'(infl_o[0]), 32'd0);
        chk("reset_busy", 32'(busy_o[0]), 32'd0);
        chk("reset_err", 32'(err_os[0]), 32'd0);

        // round-robin alternation, then in-order responses
        vld = 4'b0011; brdy = 1'b1; #1;
        chk("rr_grant0", 32'(breq_o[0]), 32'h10);
        cyc();
        chk("rr_grant1", 32'(breq_o[0]), 32'h11);
        cyc();
        chk("rr_grant2", 32'(breq_o[0]), 32'h10);
        cyc(); cyc();
        vld = '0; brsp_v = 1'b1; #1;
        chk("rr_rsp0", 32'(rspv_o[0]), 32'b0001);
        cyc();
        chk("rr_rsp1", 32'(rspv_o[0]), 32'b0010);
        cyc(); cyc(); cyc();
        brsp_v = 1'b0; #1;
        chk("rr_busy_done", 32'(busy_o[0]), 32'd0);

        // lock holds ch1 against higher-priority ch0
        do_reset();
        vld = 4'b0010; brdy = 1'b0; #1;
        cyc();
        vld = 4'b0011; #1;
        for (int i = 0; i < 3; i++) begin
            chk("lock_hold", 32'(breq_o[1]), 32'h11);
            cyc();
        end
        brdy = 1'b1; #1;
        cyc();
        chk("lock_next", 32'(breq_o[1]), 32'h10);
        cyc();

        // full FIFO blocks grants until one response
        do_reset();
        vld = 4'b0001; brdy = 1'b1; #1;
        repeat (5) cyc();
        chk("full_inflight", 32'(infl_o[0]), 32'd5);
        chk("full_no_valid", 32'(breqv_o[0]), 32'd0);
        cyc();
        brsp_v = 1'b1; #1;
        cyc();
        brsp_v = 1'b0; #1;
        chk("full_pop_inflight", 32'(infl_o[0]), 32'd4);
        chk("full_pop_valid", 32'(breqv_o[0]), 32'd1);
        cyc();
        chk("full_refill", 32'(infl_o[0]), 32'd5);

        // response backpressure on head ch2, then spurious response
        do_reset();
        vld = 4'b0100; brdy = 1'b1; #1;
        cyc();
        vld = 4'b0001; #1;
        cyc();
        vld = '0; brsp_v = 1'b1; crdy = 4'b1011; #1;
        chk("bp_rsp_ready", 32'(brspr_o[0]), 32'd0);
        chk("bp_rsp_valid", 32'(rspv_o[0]), 32'b0100);
        cyc(); cyc();
        crdy = 4'b1111; #1;
        cyc();
        chk("bp_next_head", 32'(rspv_o[0]), 32'b0001);
        cyc();
        chk("spur_ready", 32'(brspr_o[0]), 32'd0);
        chk("spur_valid", 32'(rspv_o[0]), 32'd0);
        chk("spur_err_before", 32'(err_os[0]), 32'd0);
        cyc();
        chk("spur_err_set", 32'(err_os[0]), 32'd1);
        brsp_v = 1'b0; #1;
        cyc(); cyc();
        chk("spur_err_sticky", 32'(err_os[1]), 32'd1);

        // reset with requests in flight
        vld = 4'b1111; brdy = 1'b1; #1;
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; #1;
        chk("rst_inflight", 32'(infl_o[0]), 32'd0);
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_err", 32'(err_os[0]), 32'd0);
        chk("rst_rr_ptr", 32'(breq_o[0]), 32'h10);

        // randomized traffic
        for (int t = 0; t < 800; t++) begin
            vld  = 4'($urandom);
            brdy = ($urandom % 4) != 0;
            crdy = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < N; i++) ch_req[i] = 8'($urandom);
            brsp = 8'($urandom);
            if ($urandom % 50 == 0) brsp_v = 1'b1;
            else brsp_v = (($urandom % 3) != 0) && (fq[0].size() > 0) && (fq[1].size() > 0);
            rst_n = ($urandom % 100) != 0;
            cyc();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
